switch_egress_arbiter: RTL and testbench

Egress side of one `switch_4port` output port: accepts packets already routed to this port by the fabric from up to four ingress ports, buffers each source in a small FIFO, and serializes them onto the port's output signals with round-robin fairness. It is the transmitter end of the per-port `valid_out`/`data_out` interface that bench monitors wait on. It emits at most one packet per cycle and suppresses loopback. It counts packets lost to a full FIFO.

---
 rtl/switch_egress_arbiter.sv | 137 +++++++++++++
 tb/tb_switch_egress_arbiter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/switch_egress_arbiter.sv
// Egress arbiter for one switch output port.
// Buffers packets from up to four ingress ports in per-source FIFOs and
// serializes them onto the port with round-robin fairness. Loopback traffic
// (ingress == PORT_ID) is ignored. Packets refused by a full FIFO are counted.
module switch_egress_arbiter #(
    parameter int PORT_ID    = 0,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  in_valid,
    input  logic [15:0] in_source,
    input  logic [15:0] in_target,
    input  logic [31:0] in_data,
    output logic [3:0]  in_ready,
    output logic        valid_out,
    output logic [3:0]  source_out,
    output logic [3:0]  target_out,
    output logic [7:0]  data_out,
    output logic [7:0]  drop_count
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

    typedef struct packed {
        logic [3:0] source;
        logic [3:0] target;
        logic [7:0] data;
    } entry_t;

    entry_t        mem    [4][FIFO_DEPTH];
    logic [PW-1:0] wr_ptr [4];
    logic [PW-1:0] rd_ptr [4];
    logic [CW-1:0] count  [4];

    logic [1:0] rr_ptr;
    logic       grant_valid;
    logic [1:0] grant_idx;
    logic [3:0] push;
    logic [3:0] pop;
    logic [3:0] drop;
    logic [2:0] drop_num;
    logic [8:0] drop_sum;
    entry_t     head;

    // Ready, push and drop decode from registered FIFO occupancy only.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        in_ready = '0;
        push     = '0;
        drop     = '0;
        drop_num = '0;
        for (int i = 0; i < 4; i++) begin
            if (i == PORT_ID) begin
                in_ready[i] = 1'b1;
            end else begin
                in_ready[i] = (count[i] != FULL);
                push[i]     = in_valid[i] && in_ready[i];
                drop[i]     = in_valid[i] && !in_ready[i];
            end
            drop_num = drop_num + {2'b00, drop[i]};
        end
        drop_sum = {1'b0, drop_count} + {6'd0, drop_num};
    end

    // Round-robin search starting just after the last granted input.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = rr_ptr;
        for (int k = 1; k <= 4; k++) begin
            if (!grant_valid && (count[2'(rr_ptr + k)] != '0)) begin
                grant_valid = 1'b1;
                grant_idx   = 2'(rr_ptr + k);
            end
        end
        pop  = grant_valid ? (4'b0001 << grant_idx) : 4'b0000;
        head = mem[grant_idx][rd_ptr[grant_idx]];
    end

    // FIFO pointers, occupancy, arbiter pointer and drop counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i]  <= '0;
            end
            rr_ptr     <= 2'd3;
            drop_count <= 8'd0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
            for (int i = 0; i < 4; i++) begin
                if (push[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
                if (pop[i])  rd_ptr[i] <= rd_ptr[i] + 1'b1;
                case ({push[i], pop[i]})
                    2'b10:   count[i] <= count[i] + 1'b1;
                    2'b01:   count[i] <= count[i] - 1'b1;
                    default: count[i] <= count[i];
                endcase
            end
            if (grant_valid) rr_ptr <= grant_idx;
            drop_count <= (drop_sum > 9'd255) ? 8'hFF : drop_sum[7:0];
        end
    end

    // FIFO storage write port.
    // NOTE: the storage array has no reset; occupancy counts alone decide what is valid.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (push[i]) begin
                mem[i][wr_ptr[i]] <= entry_t'({in_source[4*i +: 4],
                                               in_target[4*i +: 4],
                                               in_data[8*i +: 8]});
            end
        end
    end

    // Output register: pulse on grant, fields hold otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_out  <= 1'b0;
            source_out <= 4'd0;
            target_out <= 4'd0;
            data_out   <= 8'd0;
        end else begin
            valid_out <= grant_valid;
            if (grant_valid) begin
                source_out <= head.source;
                target_out <= head.target;
                data_out   <= head.data;
            end
        end
    end

endmodule

// File: tb/tb_switch_egress_arbiter.sv
// Self-checking bench for switch_egress_arbiter: two instances (PORT_ID 1 and 3)
// share stimulus; a per-ingress scoreboard is filled when packets are driven and
// drained by a monitor watching the instance under test.
module tb_switch_egress_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  in_valid;
    logic [15:0] in_source;
    logic [15:0] in_target;
    logic [31:0] in_data;

    logic [3:0] u1_ready, u3_ready;
    logic       u1_valid, u3_valid;
    logic [3:0] u1_src, u3_src, u1_tgt, u3_tgt;
    logic [7:0] u1_data, u3_data, u1_drop, u3_drop;

    int tests = 0;
    int fails = 0;
    int mon_sel = 1;
    bit mon_en = 1'b0;
    int pulses = 0;
    int p0;

    logic [15:0] sb [4][$];

    logic       m_valid;
    logic [3:0] m_src, m_tgt;
    logic [7:0] m_data;

    assign m_valid = (mon_sel == 1) ? u1_valid : u3_valid;
    assign m_src   = (mon_sel == 1) ? u1_src   : u3_src;
    assign m_tgt   = (mon_sel == 1) ? u1_tgt   : u3_tgt;
    assign m_data  = (mon_sel == 1) ? u1_data  : u3_data;

    always #5 clk = ~clk;

    switch_egress_arbiter #(.PORT_ID(1), .FIFO_DEPTH(4)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_source(in_source),
        .in_target(in_target), .in_data(in_data), .in_ready(u1_ready),
        .valid_out(u1_valid), .source_out(u1_src), .target_out(u1_tgt),
        .data_out(u1_data), .drop_count(u1_drop)
    );

    switch_egress_arbiter #(.PORT_ID(3), .FIFO_DEPTH(4)) u3 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_source(in_source),
        .in_target(in_target), .in_data(in_data), .in_ready(u3_ready),
        .valid_out(u3_valid), .source_out(u3_src), .target_out(u3_tgt),
        .data_out(u3_data), .drop_count(u3_drop)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic idle();
        in_valid  = '0;
        in_source = '0;
        in_target = '0;
        in_data   = '0;
    endtask

    task automatic drive(input int i, input logic [7:0] d, input logic [3:0] tgt, input bit accept);
        logic [3:0] oh;
        oh = 4'b0001 << i;
        in_valid[i]         = 1'b1;
        in_source[4*i +: 4] = oh;
        in_target[4*i +: 4] = tgt;
        in_data[8*i +: 8]   = d;
        if (accept) sb[i].push_back({oh, tgt, d});
    endtask

    task automatic clear_sb();
        for (int i = 0; i < 4; i++) sb[i].delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle();
        repeat (5) step();
        clear_sb();
        rst_n = 1'b1;
    endtask

    // Monitor: every emitted packet must match the head of its ingress queue.
    always @(negedge clk) begin
        if (mon_en && m_valid) begin
            int idx;
            pulses++;
            idx = 0;
            for (int i = 0; i < 4; i++) if (m_src[i]) idx = i;
            tests++;
            assert ($onehot(m_src)) else begin
                fails++;
                $error("FAIL mon_src_onehot: observed %0h required one-hot", m_src);
            end
            tests++;
            assert (sb[idx].size() > 0) else begin
                fails++;
                $error("FAIL mon_unexpected: observed packet %0h required none", {m_src, m_tgt, m_data});
            end
            if (sb[idx].size() > 0) check("mon_pkt", {16'd0, m_src, m_tgt, m_data}, {16'd0, sb[idx].pop_front()});
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        // Reset state.
        rst_n = 1'b0;
        repeat (5) step();
        check("rst_valid",  u1_valid, 0);
        check("rst_src",    u1_src, 0);
        check("rst_tgt",    u1_tgt, 0);
        check("rst_data",   u1_data, 0);
        check("rst_drop",   u1_drop, 0);
        check("rst_ready1", u1_ready, 4'b1111);
        check("rst_ready3", u3_ready, 4'b1111);
        check("rst_valid3", u3_valid, 0);

        // Unicast on PORT_ID 1.
        mon_sel = 1;
        mon_en  = 1'b1;
        do_reset();
        drive(0, 8'hA1, 4'b0010, 1'b1);
        step();
        idle();
        check("uni_early", u1_valid, 0);
        step();
        check("uni_valid", u1_valid, 1);
        check("uni_data",  u1_data, 8'hA1);
        check("uni_src",   u1_src, 4'b0001);
        check("uni_tgt",   u1_tgt, 4'b0010);
        step();
        check("uni_single", u1_valid, 0);
        repeat (5) step();
        check("uni_drained", sb[0].size(), 0);

        // Reset mid-burst discards buffered packets at once.
        do_reset();
        drive(0, 8'h31, 4'b0010, 1'b1);
        drive(2, 8'h32, 4'b0010, 1'b1);
        drive(3, 8'h33, 4'b0010, 1'b1);
        step();
        idle();
        step();
        check("mid_valid_before", u1_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_valid_async", u1_valid, 0);
        check("mid_ready",       u1_ready, 4'b1111);
        clear_sb();
        step();
        step();
        rst_n = 1'b1;
        p0 = pulses;
        repeat (10) step();
        check("mid_no_residual", pulses - p0, 0);

        // Contention order on PORT_ID 3.
        mon_sel = 3;
        do_reset();
        for (int r = 0; r < 2; r++) begin
            drive(0, 8'hD0, 4'b1000, 1'b1);
            drive(1, 8'hD1, 4'b1000, 1'b1);
            drive(2, 8'hD2, 4'b1000, 1'b1);
            step();
            idle();
            step();
            check("cont_d0_valid", u3_valid, 1);
            check("cont_d0", u3_data, 8'hD0);
            step();
            check("cont_d1", u3_data, 8'hD1);
            step();
            check("cont_d2", u3_data, 8'hD2);
            step();
            check("cont_end", u3_valid, 0);
        end

        // Loopback is neither stored nor counted.
        do_reset();
        drive(3, 8'hFF, 4'b1000, 1'b0);
        drive(0, 8'h5A, 4'b1000, 1'b1);
        step();
        idle();
        step();
        check("loop_valid", u3_valid, 1);
        check("loop_data",  u3_data, 8'h5A);
        step();
        check("loop_single", u3_valid, 0);
        repeat (4) step();
        check("loop_drop", u3_drop, 0);
        check("loop_drained", sb[0].size(), 0);

        // Overflow on PORT_ID 1: ingress 2 bursts, ingress 0 streams.
        mon_sel = 1;
        do_reset();
        for (int n = 0; n < 8; n++) begin
            if (n == 6) check("ovf_ready_full2", u1_ready, 4'b1011);
            if (n == 7) check("ovf_ready_full0", u1_ready, 4'b1110);
            idle();
            drive(0, 8'(8'h10 + n), 4'b0010, n != 7);
            drive(2, 8'(n), 4'b0010, n != 6);
            step();
        end
        idle();
        check("ovf_drop", u1_drop, 2);
        repeat (12) step();
        check("ovf_drained0", sb[0].size(), 0);
        check("ovf_drained2", sb[2].size(), 0);
        check("ovf_drop_hold", u1_drop, 2);
        check("ovf_ready_idle", u1_ready, 4'b1111);

        // Saturation: all inputs hammered, drops pile up past 255.
        mon_en = 1'b0;
        do_reset();
        for (int c = 0; c < 250; c++) begin
            if (c == 6) check("sat_drop_e6", u1_drop, 2);
            if (c == 7) check("sat_multi_drop", u1_drop, 4);
            for (int i = 0; i < 4; i++) drive(i, 8'(c), 4'b1010, 1'b0);
            step();
        end
        check("sat_255_u1", u1_drop, 255);
        check("sat_255_u3", u3_drop, 255);
        repeat (20) step();
        check("sat_hold", u1_drop, 255);
        idle();
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
